// File: rtl/multicycle_control_if.sv
// Handshake bundle between the multi-cycle control unit and its datapath.
// Optional illegal_op wire exists only when ILLEGAL_OP_TRAP_EN is defined.
interface multicycle_control_if #(
  parameter int ALUCTRL_WIDTH = 3,
  parameter int STATE_WIDTH   = 4
);
  logic [6:0]               op;
  logic [2:0]               funct3;
  logic                     funct7b5;
  logic                     zero;
  logic                     PCWrite;
  logic                     AdrSrc;
  logic                     MemWrite;
  logic                     IRWrite;
  logic                     RegWrite;
  logic [1:0]               ResultSrc;
  logic [1:0]               ALUSrcA;
  logic [1:0]               ALUSrcB;
  logic [ALUCTRL_WIDTH-1:0] ALUctrl;
  logic [STATE_WIDTH-1:0]   state_o;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                     illegal_op;
`endif

  modport master (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite,
    output RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    output ALUctrl, state_o
`ifdef ILLEGAL_OP_TRAP_EN
    , output illegal_op
`endif
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite,
    input  RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    input  ALUctrl, state_o
`ifdef ILLEGAL_OP_TRAP_EN
    , input illegal_op
`endif
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RV32I datapath.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes instead of skipping them.
module multicycle_control #(
  parameter int ALUCTRL_WIDTH = 3,
  parameter int STATE_WIDTH   = 4
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);
  localparam logic [STATE_WIDTH-1:0] FETCH    = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] DECODE   = STATE_WIDTH'(1);
  localparam logic [STATE_WIDTH-1:0] MEMADR   = STATE_WIDTH'(2);
  localparam logic [STATE_WIDTH-1:0] MEMREAD  = STATE_WIDTH'(3);
  localparam logic [STATE_WIDTH-1:0] MEMWB    = STATE_WIDTH'(4);
  localparam logic [STATE_WIDTH-1:0] MEMWRITE = STATE_WIDTH'(5);
  localparam logic [STATE_WIDTH-1:0] EXECR    = STATE_WIDTH'(6);
  localparam logic [STATE_WIDTH-1:0] EXECI    = STATE_WIDTH'(7);
  localparam logic [STATE_WIDTH-1:0] ALUWB    = STATE_WIDTH'(8);
  localparam logic [STATE_WIDTH-1:0] JAL      = STATE_WIDTH'(9);
  localparam logic [STATE_WIDTH-1:0] BEQ      = STATE_WIDTH'(10);
  localparam logic [STATE_WIDTH-1:0] TRAP     = STATE_WIDTH'(11);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(0);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(1);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(2);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(5);

  logic [STATE_WIDTH-1:0]   state;
  logic [STATE_WIDTH-1:0]   next;
  logic [ALUCTRL_WIDTH-1:0] alu_fn;

  // State register; reset snaps back to FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  // Next-state logic; DECODE dispatches on the opcode class.
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = DECODE;
      DECODE: begin
        if (bus.op == OP_LOAD || bus.op == OP_STORE)
          next = MEMADR;
        else if (bus.op == OP_R)   next = EXECR;
        else if (bus.op == OP_I)   next = EXECI;
        else if (bus.op == OP_JAL) next = JAL;
        else if (bus.op == OP_BEQ) next = BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
        else                       next = TRAP;
`else
        else                       next = FETCH;
`endif
      end
      MEMADR:   next = bus.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next = MEMWB;
      MEMWB:    next = FETCH;
      MEMWRITE: next = FETCH;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      ALUWB:    next = FETCH;
      JAL:      next = ALUWB;
      BEQ:      next = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:     next = TRAP;
`endif
      default:  next = FETCH;
    endcase
  end

  // ALU function decode; I-type has op[5]=0 so funct7b5 never selects sub.
  always_comb begin
    alu_fn = ALU_ADD;
    case (bus.funct3)
      3'b000:  alu_fn = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // Moore outputs; everything is held at zero while reset is asserted.
  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUctrl   = ALU_ADD;
    bus.state_o   = state;
`ifdef ILLEGAL_OP_TRAP_EN
    bus.illegal_op = 1'b0;
`endif
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.IRWrite   = 1'b1;
          bus.PCWrite   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
        end
        DECODE: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
        end
        MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        MEMREAD: bus.AdrSrc = 1'b1;
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = 1'b1;
        end
        EXECR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUctrl = alu_fn;
        end
        EXECI: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          bus.ALUctrl = alu_fn;
        end
        ALUWB: bus.RegWrite = 1'b1;
        JAL: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
        end
        BEQ: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUctrl = ALU_SUB;
          bus.PCWrite = bus.zero;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        TRAP: bus.illegal_op = 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control with a per-instruction phase model.
// Honours ILLEGAL_OP_TRAP_EN the same way the design does.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

  // phases of an instruction, as the bench sees them
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4;
  localparam int P_MW = 5, P_ER = 6, P_EI = 7, P_AWB = 8;
  localparam int P_J = 9, P_B = 10, P_T = 11;

  logic [18:0] exp_q[$];
  int checks = 0;
  int fails = 0;

  logic ill_act;
`ifdef ILLEGAL_OP_TRAP_EN
  assign ill_act = bus.illegal_op;
`else
  assign ill_act = 1'b0;
`endif

  wire [18:0] act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite,
    bus.IRWrite, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA,
    bus.ALUSrcB, bus.ALUctrl, bus.state_o, ill_act};

  function automatic logic [2:0] alu_of(logic [6:0] op,
      logic [2:0] f3, logic f7);
    if (f3 == 3'd2) return 3'd5;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd7) return 3'd2;
    if (f3 == 3'd0 && op == 7'b0110011 && f7) return 3'd1;
    return 3'd0;
  endfunction

  // expected output bundle for one phase, straight from the state table
  function automatic logic [18:0] mk(int ph, logic z,
      logic [6:0] op, logic [2:0] f3, logic f7);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0;
    logic [2:0] alu = 0;
    case (ph)
      P_F:   begin irw = 1; pcw = 1; sb = 2; rs = 2; end
      P_D:   begin sa = 1; sb = 1; end
      P_MA:  begin sa = 2; sb = 1; end
      P_MR:  adr = 1;
      P_MWB: begin rs = 1; rw = 1; end
      P_MW:  begin adr = 1; mw = 1; end
      P_ER:  begin sa = 2; alu = alu_of(op, f3, f7); end
      P_EI:  begin sa = 2; sb = 1; alu = alu_of(op, f3, f7); end
      P_AWB: rw = 1;
      P_J:   begin sa = 1; sb = 2; pcw = 1; end
      P_B:   begin sa = 2; alu = 3'd1; pcw = z; end
      P_T:   ill = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, 4'(ph), ill};
  endfunction

  // phase list per opcode class
  function automatic void phases(logic [6:0] op, output int p[$]);
    p = '{P_F, P_D};
    case (op)
      7'b0000011: p = '{P_F, P_D, P_MA, P_MR, P_MWB};
      7'b0100011: p = '{P_F, P_D, P_MA, P_MW};
      7'b0110011: p = '{P_F, P_D, P_ER, P_AWB};
      7'b0010011: p = '{P_F, P_D, P_EI, P_AWB};
      7'b1101111: p = '{P_F, P_D, P_J, P_AWB};
      7'b1100011: p = '{P_F, P_D, P_B};
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        p = '{P_F, P_D, P_T, P_T, P_T, P_T};
`endif
      end
    endcase
  endfunction

  task automatic check(string name, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  // monitor: every cycle with an outstanding expectation is compared
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [18:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        fails++;
        $display("FAIL cycle_out t=%0t act=%h exp=%h", $time, act, e);
      end
    end
  end

  // driver: one phase per cycle, entered just after a rising edge
  task automatic run_instr(logic [31:0] ins, int zmode);
    int p[$];
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[30];
    phases(op, p);
    foreach (p[k]) begin
      bus.op = op;
      bus.funct3 = f3;
      bus.funct7b5 = f7;
      bus.zero = (zmode == 2) ? 1'($urandom % 2) : 1'(zmode);
      exp_q.push_back(mk(p[k], bus.zero, op, f3, f7));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0)
      check("drain", 32'(exp_q.size()), 0);
  endtask

  logic [31:0] dir[10] = '{32'h00012283, 32'h00a12223,
    32'h002081b3, 32'h402081b3, 32'h0020a1b3, 32'h0020e1b3,
    32'h0020f1b3, 32'h40008093, 32'h00208463, 32'h00208463};
  logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
    7'b0010011, 7'b1101111, 7'b1100011};

  initial begin
    bus.op = 7'b0100011;
    bus.funct3 = 3'b010;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    #1;
    check("reset_state", 32'(bus.state_o), 0);
    check("reset_outs", 32'(act), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_fetch", {bus.IRWrite, bus.PCWrite}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    check("sw_memwrite", 32'(bus.MemWrite), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mw", 32'(bus.MemWrite), 0);
    check("async_rst_st", 32'(bus.state_o), 0);
    check("async_rst_all", 32'(act), 0);
    @(posedge clk);
    #1;
    check("rst_hold", 32'(act), 0);
    rst = 1'b0;

    foreach (dir[i])
      run_instr(dir[i], (i == 8) ? 1 : (i == 9) ? 0 : 2);
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      ins = $urandom;
`ifdef ILLEGAL_OP_TRAP_EN
      ins[6:0] = ops[$urandom_range(0, 5)];
`else
      if ($urandom_range(0, 6) != 0)
        ins[6:0] = ops[$urandom_range(0, 5)];
`endif
      run_instr(ins, 2);
    end
`ifndef ILLEGAL_OP_TRAP_EN
    run_instr(32'h0, 2);
`endif
    drain();

`ifdef ILLEGAL_OP_TRAP_EN
    run_instr(32'h0, 2);
    drain();
    check("trap_hold", {28'(bus.state_o), 3'b0, bus.illegal_op},
      {28'(P_T), 3'b0, 1'b1});
    rst = 1'b1;
    #1;
    check("trap_rst", {28'(bus.state_o), 3'b0, bus.illegal_op}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(32'h002081b3, 2);
    drain();
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequential control unit for the multi-cycle RV32I datapath.
- Decodes the latched instruction fields and steps a Moore FSM through fetch, decode, execute, memory and writeback.
- Each cycle it drives the datapath mux selects, the write enables and the 3-bit ALUctrl code consumed by the ALU.
- Samples the ALU zero flag to resolve beq.

Parameters:
- ALUCTRL_WIDTH, 3, width of the ALUctrl output; encoding fixed: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- STATE_WIDTH, 4, width of the state register and the state_o debug port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag, same cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction and oldPC register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALU result.
- ALUSrcA  out  2  operand A select: 00 PC, 01 oldPC, 10 rs1 data.
- ALUSrcB  out  2  operand B select: 00 rs2 data, 01 imm, 10 constant 4.
- ALUctrl  out  ALUCTRL_WIDTH  ALU operation.
- state_o  out  STATE_WIDTH  current state, for debug and bench.

Behaviour:
- rst high: state goes to FETCH immediately, regardless of clock. While rst is high, all outputs are forced to 0: every enable, every select, and ALUctrl=000.
- After rst falls, the first rising edge executes FETCH.
- Outputs are combinational from state only, plus zero for PCWrite. Unlisted outputs are 0 in each state.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl add, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUctrl add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - otherwise -> see Optional Feature.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUctrl from function decode. Next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUctrl from function decode. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next ALUWB (writes return address).
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero. Next FETCH.
- Function decode for EXECR/EXECI, by funct3:
  - 000: sub (001) if op[5]&funct7b5, else add (000).
  - 010: slt (101).
  - 110: or (011).
  - 111: and (010).
  - anything else: add.
  - funct7b5 is ignored for I-type because op[5]=0.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- A glitch on zero outside the BEQ state has no effect.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unrecognised op in DECODE enters TRAP. TRAP holds all outputs 0, self-loops, and drives an extra output illegal_op=1 (1 bit). Only rst leaves TRAP.
- Undefined: an unrecognised op in DECODE returns to FETCH (treated as nop, 2 cycles). No illegal_op port.

Test Plan:
- Reset mid-MEMWRITE (sw 0x00a12223): raise rst asynchronously -> MemWrite=0 the same cycle, state_o=FETCH. Release -> next edge shows IRWrite=1, PCWrite=1.
- lw 0x00012283 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. RegWrite=1 only in MEMWB, with ResultSrc=01.
- add 0x002081b3, sub 0x402081b3, slt 0x0020a1b3, or 0x0020e1b3, and 0x0020f1b3 -> ALUctrl in EXECR is 000, 001, 101, 011, 010 respectively.
- addi with funct7b5=1 (0x40008093) -> ALUctrl=000 in EXECI, not sub.
- beq 0x00208463 with zero=1 -> PCWrite=1 in BEQ. With zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- op=0000000 -> with ILLEGAL_OP_TRAP_EN: state TRAP, illegal_op=1, held until rst. Without it: back to FETCH after DECODE.
